// File: rtl/tr_rst_pkg.sv
// rtl/tr_rst_pkg.sv - state encodings and counter sizing shared by the transceiver reset sequencer
package tr_rst_pkg;

  typedef enum logic [1:0] {PLL_PD, PLL_WAIT, PLL_UP} pll_st_t;
  typedef enum logic [1:0] {TX_ARST, TX_DRST, TX_RDY} tx_st_t;
  typedef enum logic [1:0] {RX_ARST, RX_WAIT_LTD, RX_RDY} rx_st_t;

  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tr_rst_rx_ch.sv
// rtl/tr_rst_rx_ch.sv - one RX channel reset FSM with lock-stability, timeout and retry counters
module tr_rst_rx_ch
  import tr_rst_pkg::*;
#(
  parameter int T_RX_ANA = 10,
  parameter int T_RX_LTD = 500,
  parameter int T_RX_TMO = 100000,
  parameter int RETRY_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cal_busy_s,
  input  logic               i_ltd_s,
  input  logic               i_reset_req,
  output logic               o_analogreset,
  output logic               o_digitalreset,
  output logic               o_ready,
  output logic [RETRY_W-1:0] o_retry_cnt
);

  localparam int ANA_W = cnt_w(T_RX_ANA);
  localparam int LTD_W = cnt_w(T_RX_LTD);
  localparam int TMO_W = cnt_w(T_RX_TMO);
  localparam logic [ANA_W-1:0] ANA_LAST = ANA_W'(T_RX_ANA - 1);
  localparam logic [LTD_W-1:0] LTD_LAST = LTD_W'(T_RX_LTD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(T_RX_TMO - 1);

  rx_st_t             r_st;
  logic [ANA_W-1:0]   r_ana_cnt;
  logic [LTD_W-1:0]   r_ltd_cnt;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_ana;
  logic               r_dig;
  logic               r_rdy;
  logic [RETRY_W-1:0] r_retry;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_st      <= RX_ARST;
      r_ana_cnt <= '0;
      r_ltd_cnt <= '0;
      r_tmo_cnt <= '0;
      r_ana     <= 1'b1;
      r_dig     <= 1'b1;
      r_rdy     <= 1'b0;
      r_retry   <= '0;
    end else if (i_reset_req) begin
      // PCS-requested re-reset overrides every other transition and is not a retry
      r_st      <= RX_ARST;
      r_ana_cnt <= '0;
      r_ltd_cnt <= '0;
      r_tmo_cnt <= '0;
      r_ana     <= 1'b1;
      r_dig     <= 1'b1;
      r_rdy     <= 1'b0;
    end else begin
      case (r_st)
        RX_ARST: begin
          if (!i_cal_busy_s) begin
            if (r_ana_cnt == ANA_LAST) begin
              r_st      <= RX_WAIT_LTD;
              r_ana_cnt <= '0;
              r_ltd_cnt <= '0;
              r_tmo_cnt <= '0;
              r_ana     <= 1'b0;
            end else begin
              r_ana_cnt <= r_ana_cnt + 1'b1;
            end
          end else begin
            r_ana_cnt <= '0;
          end
        end
        RX_WAIT_LTD: begin
          if (i_ltd_s && (r_ltd_cnt == LTD_LAST)) begin
            r_st      <= RX_RDY;
            r_ltd_cnt <= '0;
            r_tmo_cnt <= '0;
            r_dig     <= 1'b0;
            r_rdy     <= 1'b1;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_st      <= RX_ARST;
            r_ana_cnt <= '0;
            r_ltd_cnt <= '0;
            r_tmo_cnt <= '0;
            r_ana     <= 1'b1;
            if (r_retry != '1) begin
              r_retry <= r_retry + 1'b1;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_ltd_cnt <= i_ltd_s ? r_ltd_cnt + 1'b1 : '0;
          end
        end
        RX_RDY: begin
          if (!i_ltd_s) begin
            r_st      <= RX_WAIT_LTD;
            r_ltd_cnt <= '0;
            r_tmo_cnt <= '0;
            r_dig     <= 1'b1;
            r_rdy     <= 1'b0;
          end
        end
        default: begin
          r_st <= RX_ARST;
        end
      endcase
    end
  end

  assign o_analogreset  = r_ana;
  assign o_digitalreset = r_dig;
  assign o_ready        = r_rdy;
  assign o_retry_cnt    = r_retry;

endmodule

// File: rtl/tr_rst_seq.sv
// rtl/tr_rst_seq.sv - shared TX PLL plus NCH-channel transceiver reset sequencer with per-channel RX recovery
module tr_rst_seq
  import tr_rst_pkg::*;
#(
  parameter int NCH         = 1,
  parameter int SYNC_STAGES = 2,
  parameter int T_PLL_PD    = 100,
  parameter int T_TX_ANA    = 10,
  parameter int T_TX_DIG    = 20,
  parameter int T_RX_ANA    = 10,
  parameter int T_RX_LTD    = 500,
  parameter int T_RX_TMO    = 100000,
  parameter int RETRY_W     = 8
) (
  input  logic                   i_clk_glbl,
  input  logic                   i_rst_glbl_n,
  output logic                   o_pll_powerdown,
  input  logic                   i_pll_locked,
  input  logic                   i_pll_cal_busy,
  output logic [NCH-1:0]         o_tx_analogreset,
  output logic [NCH-1:0]         o_tx_digitalreset,
  input  logic [NCH-1:0]         i_tx_cal_busy,
  output logic [NCH-1:0]         o_tx_ready,
  output logic [NCH-1:0]         o_rx_analogreset,
  output logic [NCH-1:0]         o_rx_digitalreset,
  input  logic [NCH-1:0]         i_rx_cal_busy,
  input  logic [NCH-1:0]         i_rx_is_lockedtodata,
  input  logic [NCH-1:0]         i_rx_reset_req,
  output logic [NCH-1:0]         o_rx_ready,
  output logic [NCH*RETRY_W-1:0] o_rx_retry_cnt
);

  localparam int PD_W = cnt_w(T_PLL_PD);
  localparam int TX_W = max_w(cnt_w(T_TX_ANA), cnt_w(T_TX_DIG));
  localparam logic [PD_W-1:0] PD_LAST  = PD_W'(T_PLL_PD - 1);
  localparam logic [TX_W-1:0] TXA_LAST = TX_W'(T_TX_ANA - 1);
  localparam logic [TX_W-1:0] TXD_LAST = TX_W'(T_TX_DIG - 1);
  localparam int SW = 2 + 3 * NCH;
  // cal_busy bits reset high so nothing proceeds before calibration status is actually seen
  localparam logic [SW-1:0] SYNC_RST = {{NCH{1'b0}}, {NCH{1'b1}}, {NCH{1'b1}}, 1'b1, 1'b0};

  logic [SW-1:0]  w_async;
  logic [SW-1:0]  w_sync;
  logic [SW-1:0]  r_sync [SYNC_STAGES];
  logic           w_pll_locked_s;
  logic           w_pll_cal_busy_s;
  logic [NCH-1:0] w_tx_cal_busy_s;
  logic [NCH-1:0] w_rx_cal_busy_s;
  logic [NCH-1:0] w_rx_ltd_s;

  assign w_async = {i_rx_is_lockedtodata, i_rx_cal_busy, i_tx_cal_busy, i_pll_cal_busy, i_pll_locked};
  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign {w_rx_ltd_s, w_rx_cal_busy_s, w_tx_cal_busy_s, w_pll_cal_busy_s, w_pll_locked_s} = w_sync;

  always_ff @(posedge i_clk_glbl or negedge i_rst_glbl_n) begin
    if (!i_rst_glbl_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= SYNC_RST;
      end
    end else begin
      r_sync[0] <= w_async;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
    end
  end

  pll_st_t         r_pll_st;
  logic [PD_W-1:0] r_pll_cnt;
  logic            r_pll_pd;
  logic            w_pll_ok;

  always_ff @(posedge i_clk_glbl or negedge i_rst_glbl_n) begin
    if (!i_rst_glbl_n) begin
      r_pll_st  <= PLL_PD;
      r_pll_cnt <= '0;
      r_pll_pd  <= 1'b1;
    end else begin
      case (r_pll_st)
        PLL_PD: begin
          if (r_pll_cnt == PD_LAST) begin
            r_pll_st  <= PLL_WAIT;
            r_pll_cnt <= '0;
            r_pll_pd  <= 1'b0;
          end else begin
            r_pll_cnt <= r_pll_cnt + 1'b1;
          end
        end
        PLL_WAIT: begin
          if (w_pll_locked_s && !w_pll_cal_busy_s) begin
            r_pll_st <= PLL_UP;
          end
        end
        PLL_UP: begin
          if (!w_pll_locked_s) begin
            r_pll_st <= PLL_WAIT;
          end
        end
        default: begin
          r_pll_st <= PLL_PD;
        end
      endcase
    end
  end

  assign w_pll_ok = (r_pll_st == PLL_UP);

  tx_st_t          r_tx_st  [NCH];
  logic [TX_W-1:0] r_tx_cnt [NCH];
  logic [NCH-1:0]  r_tx_ana;
  logic [NCH-1:0]  r_tx_dig;
  logic [NCH-1:0]  r_tx_rdy;

  always_ff @(posedge i_clk_glbl or negedge i_rst_glbl_n) begin
    if (!i_rst_glbl_n) begin
      for (int c = 0; c < NCH; c++) begin
        r_tx_st[c]  <= TX_ARST;
        r_tx_cnt[c] <= '0;
      end
      r_tx_ana <= '1;
      r_tx_dig <= '1;
      r_tx_rdy <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        case (r_tx_st[c])
          TX_ARST: begin
            if (w_pll_ok && !w_tx_cal_busy_s[c]) begin
              if (r_tx_cnt[c] == TXA_LAST) begin
                r_tx_st[c]  <= TX_DRST;
                r_tx_cnt[c] <= '0;
                r_tx_ana[c] <= 1'b0;
              end else begin
                r_tx_cnt[c] <= r_tx_cnt[c] + 1'b1;
              end
            end else begin
              r_tx_cnt[c] <= '0;
            end
          end
          TX_DRST: begin
            if (w_pll_locked_s) begin
              if (r_tx_cnt[c] == TXD_LAST) begin
                r_tx_st[c]  <= TX_RDY;
                r_tx_cnt[c] <= '0;
                r_tx_dig[c] <= 1'b0;
                r_tx_rdy[c] <= 1'b1;
              end else begin
                r_tx_cnt[c] <= r_tx_cnt[c] + 1'b1;
              end
            end else begin
              r_tx_cnt[c] <= '0;
            end
          end
          TX_RDY: begin
            // a lock drop only needs the digital side re-reset; analog stays released
            if (!w_pll_locked_s) begin
              r_tx_st[c]  <= TX_DRST;
              r_tx_cnt[c] <= '0;
              r_tx_dig[c] <= 1'b1;
              r_tx_rdy[c] <= 1'b0;
            end
          end
          default: begin
            r_tx_st[c] <= TX_ARST;
          end
        endcase
      end
    end
  end

  assign o_pll_powerdown   = r_pll_pd;
  assign o_tx_analogreset  = r_tx_ana;
  assign o_tx_digitalreset = r_tx_dig;
  assign o_tx_ready        = r_tx_rdy;

  for (genvar c = 0; c < NCH; c++) begin : g_rx
    tr_rst_rx_ch #(
      .T_RX_ANA (T_RX_ANA),
      .T_RX_LTD (T_RX_LTD),
      .T_RX_TMO (T_RX_TMO),
      .RETRY_W  (RETRY_W)
    ) u_rx_ch (
      .i_clk          (i_clk_glbl),
      .i_rst_n        (i_rst_glbl_n),
      .i_cal_busy_s   (w_rx_cal_busy_s[c]),
      .i_ltd_s        (w_rx_ltd_s[c]),
      .i_reset_req    (i_rx_reset_req[c]),
      .o_analogreset  (o_rx_analogreset[c]),
      .o_digitalreset (o_rx_digitalreset[c]),
      .o_ready        (o_rx_ready[c]),
      .o_retry_cnt    (o_rx_retry_cnt[c*RETRY_W +: RETRY_W])
    );
  end

endmodule
